// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the tiny processor.
//   OP_NOP / OP_HALT : opcodes the fetch unit and decoder both care about
//   state_t          : fetch-unit FSM states, also exported for debug
package cpu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the program-load port, the decoder-facing fetch port
// and the status outputs of instr_fetch.
//   load_valid/load_data/load_last/load_ready : byte stream into program memory
//   start, next_pc                            : control from the decoder side
//   instruction/current_pc/instr_valid        : registered fetch result
//   halted/loaded/load_count                  : status
//   dbg_state                                 : FSM state for observation
//
// Handshake: a byte transfers on a rising clk edge where load_valid and
// load_ready are both high. load_ready depends only on the fetch unit's state
// and never on load_valid; the source may raise load_valid at any time and
// must hold load_data/load_last stable until the byte is accepted.
interface instr_fetch_if #(
  parameter int DEPTH = 256
);
  import cpu_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              start;
  logic [7:0]        next_pc;
  logic [7:0]        instruction;
  logic [7:0]        current_pc;
  logic              instr_valid;
  logic              halted;
  logic              loaded;
  logic [ADDR_W:0]   load_count;
  state_t            dbg_state;

  // Driving side: loader and decoder.
  modport master (
    output load_valid, load_data, load_last, start, next_pc,
    input  load_ready, instruction, current_pc, instr_valid,
           halted, loaded, load_count, dbg_state
  );

  // The fetch unit itself.
  modport slave (
    input  load_valid, load_data, load_last, start, next_pc,
    output load_ready, instruction, current_pc, instr_valid,
           halted, loaded, load_count, dbg_state
  );

endinterface

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x 8 program memory, one synchronous write port and one
// asynchronous read port. Contents are never cleared.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module prog_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program-load and instruction-fetch unit.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : instr_fetch_if slave (load port, fetch port, status, debug state)
// IDLE accepts program bytes until load_last or memory full; start enters RUN,
// which presents one instruction per cycle at the decoder's next_pc. A 0xFF
// instruction moves to HALT, from where the unit can restart or be reloaded.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              loaded_q, loaded_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic              load_ready;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        fetch_data;

  prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_prog_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (bus.load_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Outside RUN the only fetch ever needed is address 0 (the start entry).
  // Upper next_pc bits are dropped; unloaded slots read as NOP.
  always_comb begin
    rd_addr    = (state_q == RUN) ? bus.next_pc[ADDR_W-1:0] : '0;
    fetch_data = ({1'b0, rd_addr} < count_q) ? rd_data : OP_NOP;
  end

  always_comb begin
    case (state_q)
      IDLE:    load_ready = !loaded_q;
      HALT:    load_ready = 1'b1;
      default: load_ready = 1'b0;
    endcase
  end

  assign accept = bus.load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    loaded_d  = loaded_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[ADDR_W-1:0];

    case (state_q)
      IDLE: begin
        if (accept) begin
          mem_we  = 1'b1;
          count_d = count_q + 1'b1;
          if (bus.load_last || count_q == LAST_SLOT) begin
            loaded_d = 1'b1;
          end
        end else if (bus.start && loaded_q) begin
          state_d = RUN;
          pc_d    = 8'h00;
          instr_d = fetch_data;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        // The instruction register holds what the decoder is executing now;
        // HALT freezes it so the final pc/instruction stay visible.
        if (instr_q == OP_HALT) begin
          state_d  = HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else begin
          pc_d    = bus.next_pc;
          instr_d = fetch_data;
        end
      end
      HALT: begin
        if (accept) begin
          // Reload: the new program overwrites from address 0.
          mem_we    = 1'b1;
          mem_waddr = '0;
          count_d   = (ADDR_W+1)'(1);
          loaded_d  = bus.load_last;
          halted_d  = 1'b0;
          state_d   = IDLE;
        end else if (bus.start) begin
          state_d  = RUN;
          pc_d     = 8'h00;
          instr_d  = fetch_data;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= 8'h00;
      instr_q  <= OP_NOP;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      loaded_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      loaded_q <= loaded_d;
      count_q  <= count_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.instruction = instr_q;
  assign bus.current_pc  = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
  assign bus.loaded      = loaded_q;
  assign bus.load_count  = count_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch. One DEPTH=256 instance
// runs the program scenarios through a (pc, instruction) scoreboard; a DEPTH=4
// instance covers the memory-full and address-wrap boundaries.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk;
  logic reset;

  instr_fetch_if #(.DEPTH(256)) b256 ();
  instr_fetch_if #(.DEPTH(4))   b4 ();

  instr_fetch #(.DEPTH(256)) u_dut256 (.clk(clk), .reset(reset), .bus(b256));
  instr_fetch #(.DEPTH(4))   u_dut4   (.clk(clk), .reset(reset), .bus(b4));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_item;
  logic [7:0]  m_mem [256];
  int          m_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] mfetch(input logic [7:0] a);
    if (int'(a) < m_cnt) return m_mem[a];
    return OP_NOP;
  endfunction

  // Every cycle the 256-deep unit flags a valid instruction, it must match the
  // oldest expected (pc, instruction) pair.
  always @(posedge clk) begin
    #2;
    if (b256.instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check_eq("sb_pc", 32'(b256.current_pc), 32'(exp_item[15:8]));
        check_eq("sb_instr", 32'(b256.instruction), 32'(exp_item[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load256(input logic [7:0] d, input logic last);
    b256.load_valid = 1'b1;
    b256.load_data  = d;
    b256.load_last  = last;
    tick();
    b256.load_valid = 1'b0;
    b256.load_last  = 1'b0;
  endtask

  task automatic load4(input logic [7:0] d);
    b4.load_valid = 1'b1;
    b4.load_data  = d;
    b4.load_last  = 1'b0;
    tick();
    b4.load_valid = 1'b0;
  endtask

  task automatic start256(input logic push_entry);
    b256.start = 1'b1;
    if (push_entry) exp_q.push_back({8'h00, mfetch(8'h00)});
    tick();
    b256.start = 1'b0;
  endtask

  task automatic run_step(input logic [7:0] a);
    b256.next_pc = a;
    exp_q.push_back({a, mfetch(a)});
    tick();
  endtask

  task automatic check_reset256(input string tag);
    check_eq({tag, "_state"},  32'(b256.dbg_state), 32'(IDLE));
    check_eq({tag, "_pc"},     32'(b256.current_pc), 32'h0);
    check_eq({tag, "_instr"},  32'(b256.instruction), 32'h0);
    check_eq({tag, "_valid"},  32'(b256.instr_valid), 32'h0);
    check_eq({tag, "_halted"}, 32'(b256.halted), 32'h0);
    check_eq({tag, "_loaded"}, 32'(b256.loaded), 32'h0);
    check_eq({tag, "_count"},  32'(b256.load_count), 32'h0);
    check_eq({tag, "_ready"},  32'(b256.load_ready), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    b256.load_valid = 1'b0; b256.load_data = 8'h00; b256.load_last = 1'b0;
    b256.start = 1'b0; b256.next_pc = 8'h00;
    b4.load_valid = 1'b0; b4.load_data = 8'h00; b4.load_last = 1'b0;
    b4.start = 1'b0; b4.next_pc = 8'h00;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset256("rst");
    check_eq("rst4_ready", 32'(b4.load_ready), 32'h1);

    // Program 1: 0x91 0x06 0xFF, runs to HALT.
    load256(8'h91, 1'b0); m_mem[0] = 8'h91;
    load256(8'h06, 1'b0); m_mem[1] = 8'h06;
    load256(8'hFF, 1'b1); m_mem[2] = 8'hFF;
    m_cnt = 3;
    check_eq("p1_loaded", 32'(b256.loaded), 32'h1);
    check_eq("p1_ready",  32'(b256.load_ready), 32'h0);
    check_eq("p1_count",  32'(b256.load_count), 32'd3);
    start256(1'b1);
    check_eq("p1_run", 32'(b256.dbg_state), 32'(RUN));
    run_step(8'd1);
    run_step(8'd2);
    b256.next_pc = 8'd3;
    tick();
    check_eq("p1_halted", 32'(b256.halted), 32'h1);
    check_eq("p1_hvalid", 32'(b256.instr_valid), 32'h0);
    check_eq("p1_hstate", 32'(b256.dbg_state), 32'(HALT));
    check_eq("p1_hpc",    32'(b256.current_pc), 32'd2);
    check_eq("p1_hinstr", 32'(b256.instruction), 32'hFF);
    check_eq("p1_hready", 32'(b256.load_ready), 32'h1);
    check_eq("p1_hcount", 32'(b256.load_count), 32'd3);

    // Restart from HALT without reloading.
    start256(1'b1);
    check_eq("rs_halted", 32'(b256.halted), 32'h0);
    run_step(8'd1);
    run_step(8'd2);
    b256.next_pc = 8'd3;
    tick();
    check_eq("rs_halted2", 32'(b256.halted), 32'h1);

    // Reload 8 random non-HALT bytes from HALT.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 254));
      m_mem[i] = d;
      load256(d, i == 7);
      if (i == 0) begin
        check_eq("rl_state",  32'(b256.dbg_state), 32'(IDLE));
        check_eq("rl_count1", 32'(b256.load_count), 32'd1);
        check_eq("rl_halted", 32'(b256.halted), 32'h0);
        check_eq("rl_loaded", 32'(b256.loaded), 32'h0);
      end
    end
    m_cnt = 8;
    check_eq("rl_count8",  32'(b256.load_count), 32'd8);
    check_eq("rl_loaded8", 32'(b256.loaded), 32'h1);
    start256(1'b1);
    run_step(8'd1);
    run_step(8'd5);
    run_step(8'd8);
    run_step(8'hFF);
    run_step(8'd3);
    run_step(8'd7);
    check_eq("r7_pc", 32'(b256.current_pc), 32'd7);

    // Reset in the middle of RUN.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_cnt = 0;
    check_reset256("rrun");

    // Load and start together while not loaded: byte taken, stay IDLE.
    b256.start = 1'b1;
    load256(8'h2A, 1'b0);
    b256.start = 1'b0;
    m_mem[0] = 8'h2A; m_cnt = 1;
    check_eq("ls_state", 32'(b256.dbg_state), 32'(IDLE));
    check_eq("ls_count", 32'(b256.load_count), 32'd1);
    load256(8'hFF, 1'b1);
    m_mem[1] = 8'hFF; m_cnt = 2;
    check_eq("ls_loaded", 32'(b256.loaded), 32'h1);
    start256(1'b1);
    check_eq("ls_run", 32'(b256.dbg_state), 32'(RUN));
    run_step(8'd2);
    run_step(8'hFF);
    run_step(8'd1);
    b256.next_pc = 8'd2;
    tick();
    check_eq("ls_halted", 32'(b256.halted), 32'h1);

    // In HALT, load and start together: load wins.
    b256.start = 1'b1;
    load256(8'h33, 1'b0);
    b256.start = 1'b0;
    check_eq("hl_state",  32'(b256.dbg_state), 32'(IDLE));
    check_eq("hl_loaded", 32'(b256.loaded), 32'h0);
    check_eq("hl_count",  32'(b256.load_count), 32'd1);
    check_eq("hl_halted", 32'(b256.halted), 32'h0);
    check_eq("hl_valid",  32'(b256.instr_valid), 32'h0);

    // DEPTH=4: fill without load_last, refuse a fifth byte, wrap addresses.
    load4(8'h11);
    load4(8'h22);
    load4(8'h33);
    check_eq("d4_loaded3", 32'(b4.loaded), 32'h0);
    load4(8'h44);
    check_eq("d4_loaded4", 32'(b4.loaded), 32'h1);
    check_eq("d4_ready",   32'(b4.load_ready), 32'h0);
    check_eq("d4_count4",  32'(b4.load_count), 32'd4);
    load4(8'h55);
    check_eq("d4_count5",  32'(b4.load_count), 32'd4);
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    check_eq("d4_pc0",    32'(b4.current_pc), 32'd0);
    check_eq("d4_instr0", 32'(b4.instruction), 32'h11);
    check_eq("d4_valid",  32'(b4.instr_valid), 32'h1);
    b4.next_pc = 8'd4;
    tick();
    check_eq("d4_pc4",    32'(b4.current_pc), 32'd4);
    check_eq("d4_instr4", 32'(b4.instruction), 32'h11);
    b4.next_pc = 8'd6;
    tick();
    check_eq("d4_pc6",    32'(b4.current_pc), 32'd6);
    check_eq("d4_instr6", 32'(b4.instruction), 32'h33);

    tick();
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and program-load unit for the tiny processor. It accepts a program as a stream of bytes over a valid/ready load port and stores it in an internal program memory. On `start` it supplies one instruction per cycle to the decoder, together with the matching `current_pc`. Each cycle it takes the decoder's combinational `next_pc` as the next fetch address and detects HALT (0xFF) to stop execution.

## Interface
- `DEPTH`, 256: program memory entries (power of 2, 2..256); `ADDR_W = $clog2(DEPTH)`.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `load_valid` input 1: `load_data` byte is offered.
- `load_data` input 8: program byte.
- `load_last` input 1: qualifies the final byte of the program.
- `load_ready` output 1: unit accepts a byte this cycle.
- `start` input 1: begin execution at PC 0.
- `next_pc` input 8: decoder's next PC for the current instruction.
- `instruction` output 8: instruction at `current_pc`.
- `current_pc` output 8: PC of `instruction`.
- `instr_valid` output 1: the top level gates every decoder write enable with this signal.
- `halted` output 1: HALT reached.
- `loaded` output 1: a complete program is present.
- `load_count` output ADDR_W+1: number of bytes stored.

## Operation
- States: IDLE, RUN, HALT.
- Reset values: state=IDLE, `current_pc`=0, `instruction`=0x00, `instr_valid`=0, `halted`=0, `loaded`=0, `load_count`=0, `load_ready`=1. Memory contents are not cleared.
- **IDLE**
  - `load_ready` = !`loaded`.
  - Accept when `load_valid` & `load_ready`: write mem[`load_count`] = `load_data`, then increment `load_count`.
  - `loaded` is set after an accepted byte with `load_last`=1, or after the DEPTH-th byte (full). Further bytes are refused while `loaded`=1.
  - `start` is honoured only when `loaded`=1 and no byte is accepted in the same cycle; otherwise it is ignored (load has priority).
  - On an honoured `start`: `current_pc`<=0, `instruction`<=fetch(0), `instr_valid`<=1, go to RUN.
- **RUN**, every cycle:
  - `current_pc` <= `next_pc`.
  - `instruction` <= fetch(`next_pc`).
  - If `instruction`==0xFF: go to HALT instead. PC and `instruction` hold, `instr_valid`<=0, `halted`<=1.
  - `load_ready`=0 and `start` is ignored.
- **fetch(a)** = mem[a[ADDR_W-1:0]] if a[ADDR_W-1:0] < `load_count`, else 0x00 (NOP, which the decoder treats as PC+1). Address bits above ADDR_W are discarded.
- PC arithmetic belongs to the decoder. PC 255 followed by PC+1 yields 0 with 8-bit wrap; the unit requires no special case.
- **HALT**
  - `start` restarts at PC 0, with the same entry behaviour as from IDLE; `halted` clears.
  - `load_ready`=1. An accepted byte clears `loaded`, writes mem[0], sets `load_count`=1, clears `halted`, and goes to IDLE (reload). If that byte carries `load_last`, `loaded` is set again.
  - `start` and a load in the same cycle: load wins.
- `reset` in any state, including mid-load or mid-run, returns to the reset values on the next edge.

## Timing
- Load: one byte per cycle while `load_ready`=1. `load_ready` is combinational from state and `loaded`.
- Start to first instruction: `instruction`/`current_pc`/`instr_valid` are valid on the edge after `start`.
- Throughput: one instruction per cycle. `instruction` and `current_pc` are registered and always consistent with each other.
- The `next_pc` input to fetch path is combinational: asynchronous memory read feeding the instruction register.
- HALT: `instr_valid` is high for the 0xFF cycle; `halted`=1 and `instr_valid`=0 from the next edge.

## Structure
- Package `cpu_pkg`: `OP_HALT`=8'hFF, `OP_NOP`=8'h00, state enum {IDLE, RUN, HALT}. The decoder's opcode constants move here as well.
- Sub-module `prog_mem`: DEPTH×8, one synchronous write port and one asynchronous read port.
- The FSM, PC/instruction registers and load counter live in `instr_fetch`.

## Test plan
- Load 0x91, 0x06, 0xFF (`load_last` on 0xFF), then `start` → `instr_valid` cycles show (pc,instr) = (0,0x91), (1,0x06), (2,0xFF); `halted`=1 the following cycle; `load_count`=3.
- In RUN at pc 1, drive `next_pc`=0x05 with 8 bytes loaded → next cycle `current_pc`=5, `instruction`=mem[5].
- With 2 bytes loaded, `next_pc`=2 → `instruction`=0x00; `next_pc`=0xFF with DEPTH=256 → 0x00.
- In IDLE, `load_valid` and `start` in the same cycle (`loaded` already set is impossible because `load_ready`=0, so test with `loaded`=0) → byte written, stays in IDLE; with `loaded`=1, `start` alone → RUN.
- DEPTH=4, four bytes with no `load_last` → `loaded`=1 after the 4th; `load_ready`=0; a 5th `load_valid` is not accepted.
- `reset` asserted in RUN at pc 7 → next cycle IDLE, pc 0, `instr_valid`=0, `load_count`=0, `load_ready`=1.
